mjpg_stream_reader: RTL and testbench

- Receive end of the MJPEG byte stream that the encoder emits as 8-bit valid/data bytes.
- Parse markers: SOI, SOF0, SOS, EOI and any length-prefixed segment.
- Capture frame width and height from SOF0.
- Inside a scan, remove the 0x00 stuffed after each 0xFF and present an MSB-first bit window to a downstream Huffman/entropy decoder, which consumes 0..32 bits per cycle.

---
 rtl/mjpg_pkg.sv | 61 ++++++
 rtl/mjpg_stream_reader_if.sv | 11 +
 rtl/mjpg_bit_window.sv | 67 ++++++
 rtl/mjpg_stream_reader.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mjpg_stream_reader.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mjpg_pkg.sv
// mjpg_pkg: shared constants, parser state type and marker-code decoder for
// the MJPEG stream reader.
package mjpg_pkg;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned DIM_W = 12;

    localparam logic [7:0] MK_FF   = 8'hFF;
    localparam logic [7:0] MK_SOI  = 8'hD8;
    localparam logic [7:0] MK_EOI  = 8'hD9;
    localparam logic [7:0] MK_SOF0 = 8'hC0;
    localparam logic [7:0] MK_SOS  = 8'hDA;
    localparam logic [7:0] MK_DHT  = 8'hC4;
    localparam logic [7:0] MK_DQT  = 8'hDB;
    localparam logic [7:0] MK_RST0 = 8'hD0;
    localparam logic [7:0] MK_RST7 = 8'hD7;
    localparam logic [7:0] MK_TEM  = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_LEN,
        ST_BODY,
        ST_SCAN
    } state_e;

    typedef struct packed {
        state_e nxt;
        logic   sof;
        logic   sos;
        logic   soi;
    } mark_dec_t;

    // RST0..RST7 share the upper five bits 11010.
    function automatic logic is_rst_marker(input logic [7:0] b);
        return (b[7:3] == MK_RST0[7:3]);
    endfunction

    // Decision for the byte that follows an 0xFF: next state plus segment flags.
    function automatic mark_dec_t decode_marker(input logic [7:0] b);
        mark_dec_t d;
        d.nxt = ST_LEN;
        d.sof = 1'b0;
        d.sos = 1'b0;
        d.soi = 1'b0;
        if (b == MK_SOI) begin
            d.soi = 1'b1;
            d.nxt = ST_IDLE;
        end else if (b == MK_FF) begin
            d.nxt = ST_MARK;
        end else if (b == MK_SOF0) begin
            d.sof = 1'b1;
        end else if (b == MK_SOS) begin
            d.sos = 1'b1;
        end else if (b == MK_EOI || b == MK_TEM || is_rst_marker(b)) begin
            d.nxt = ST_IDLE;
        end
        return d;
    endfunction

endpackage

// File: rtl/mjpg_stream_reader_if.sv
// mjpg_stream_reader_if: 8-bit valid/ready byte stream into the reader.
interface mjpg_stream_reader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/mjpg_bit_window.sv
// mjpg_bit_window: MSB-first bit accumulator. Each cycle it drops up to
// take_i leading bits and may append one byte directly below the bits that
// remain. Asking for more bits than are held flags over_o and clamps.
module mjpg_bit_window
    import mjpg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [5:0]       take_i,
    input  logic             append_i,
    input  logic [7:0]       byte_i,
    output logic [ACC_W-1:0] win_o,
    output logic [5:0]       win_len_o,
    output logic             over_o
);

    localparam logic [5:0] APPEND_TOP = 6'(ACC_W - 8);

    logic [ACC_W-1:0] win_q, win_d;
    logic [5:0]       len_q, len_d;
    logic [5:0]       t;
    logic [5:0]       rem;
    logic [5:0]       sh;

    // Next window: clamp the take, shift out consumed bits, place the new byte.
    always_comb begin
        t      = '0;
        over_o = 1'b0;
        if (en_i) begin
            if (take_i > len_q) begin
                t      = len_q;
                over_o = 1'b1;
            end else begin
                t = take_i;
            end
        end
        rem   = len_q - t;
        sh    = APPEND_TOP - rem;
        win_d = win_q << t;
        len_d = rem;
        if (en_i && append_i) begin
            win_d = win_d | ({{(ACC_W-8){1'b0}}, byte_i} << sh);
            len_d = rem + 6'd8;
        end
        if (clear_i) begin
            win_d = '0;
            len_d = '0;
        end
    end

    // Window registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
            len_q <= '0;
        end else begin
            win_q <= win_d;
            len_q <= len_d;
        end
    end

    assign win_o     = win_q;
    assign win_len_o = len_q;

endmodule

// File: rtl/mjpg_stream_reader.sv
// mjpg_stream_reader: MJPEG byte-stream receiver. Walks markers and
// length-prefixed segments, captures SOF0 dimensions, and inside a scan strips
// FF-00 stuffing and feeds entropy bits into mjpg_bit_window.
// Optional: define MJPG_READER_STATS_EN to add saturating byte/unstuff/frame
// counters.
module mjpg_stream_reader
    import mjpg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mjpg_stream_reader_if.slave  in_bus,
    output logic [ACC_W-1:0]     win,
    output logic [5:0]           win_len,
    input  logic [5:0]           take,
    output logic                 frame_start,
    output logic                 scan_start,
    output logic                 scan_done,
    output logic                 in_scan,
    output logic [DIM_W-1:0]     width,
    output logic [DIM_W-1:0]     height,
    output logic                 err
`ifdef MJPG_READER_STATS_EN
    ,
    output logic [31:0]          stat_bytes,
    output logic [31:0]          stat_unstuff,
    output logic [31:0]          stat_frames
`endif
);

    state_e           state_q;
    logic             pending_ff_q;
    logic [15:0]      seg_cnt_q;
    logic             len_lo_q;
    logic             sof_q;
    logic             sos_q;
    logic [2:0]       body_idx_q;
    logic [DIM_W-1:0] width_q;
    logic [DIM_W-1:0] height_q;
    logic             err_q;
    logic             frame_start_q;
    logic             scan_start_q;
    logic             scan_done_q;
    logic             in_scan_q;

    logic             in_ready_w;
    logic             acc;
    logic [7:0]       din;
    logic [15:0]      len_w;
    mark_dec_t        md_w;
    logic             mark_now;
    logic             win_append;
    logic             win_clear;
    logic [7:0]       win_byte;
    logic             win_over;
    logic             win_en;

    assign din        = in_bus.in_data;
    assign win_en     = (state_q == ST_SCAN);
    // An FF is only taken with room for a byte; while it is pending the window
    // cannot grow, so the following stuff 00 is never refused.
    assign in_ready_w = (state_q != ST_SCAN) || (win_len <= 6'd24) || pending_ff_q;
    assign in_bus.in_ready = in_ready_w;
    assign acc        = in_bus.in_valid && in_ready_w;
    assign len_w      = {seg_cnt_q[15:8], din};

    // Byte routing: decode marker codes and choose what enters the window.
    always_comb begin
        md_w       = decode_marker(din);
        mark_now   = 1'b0;
        win_append = 1'b0;
        win_clear  = 1'b0;
        win_byte   = din;
        if (acc && state_q == ST_MARK) begin
            mark_now = 1'b1;
        end
        if (acc && state_q == ST_SCAN) begin
            if (!pending_ff_q) begin
                win_append = (din != MK_FF);
            end else if (din == 8'h00) begin
                win_append = 1'b1;
                win_byte   = MK_FF;
            end else if (din != MK_FF && !is_rst_marker(din)) begin
                // EOI or an unexpected marker ends the scan.
                win_clear = 1'b1;
                mark_now  = (din != MK_EOI);
            end
        end
    end

    mjpg_bit_window u_win (
        .clk       (clk),
        .rst       (rst),
        .en_i      (win_en),
        .clear_i   (win_clear),
        .take_i    (take),
        .append_i  (win_append),
        .byte_i    (win_byte),
        .win_o     (win),
        .win_len_o (win_len),
        .over_o    (win_over)
    );

    // Marker/segment parser with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pending_ff_q  <= 1'b0;
            seg_cnt_q     <= '0;
            len_lo_q      <= 1'b0;
            sof_q         <= 1'b0;
            sos_q         <= 1'b0;
            body_idx_q    <= '0;
            width_q       <= '0;
            height_q      <= '0;
            err_q         <= 1'b0;
            frame_start_q <= 1'b0;
            scan_start_q  <= 1'b0;
            scan_done_q   <= 1'b0;
            in_scan_q     <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            scan_start_q  <= 1'b0;
            scan_done_q   <= 1'b0;
            if (win_over) begin
                err_q <= 1'b1;
            end
            if (acc) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (din == MK_FF) begin
                            state_q <= ST_MARK;
                        end
                    end
                    ST_MARK: begin
                        // handled by the shared marker block below
                    end
                    ST_LEN: begin
                        if (!len_lo_q) begin
                            seg_cnt_q[15:8] <= din;
                            len_lo_q        <= 1'b1;
                        end else begin
                            len_lo_q   <= 1'b0;
                            body_idx_q <= '0;
                            if (len_w < 16'd2) begin
                                err_q     <= 1'b1;
                                seg_cnt_q <= '0;
                                state_q   <= ST_IDLE;
                            end else if (len_w == 16'd2) begin
                                seg_cnt_q <= '0;
                                if (sos_q) begin
                                    state_q      <= ST_SCAN;
                                    scan_start_q <= 1'b1;
                                    in_scan_q    <= 1'b1;
                                    pending_ff_q <= 1'b0;
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end else begin
                                seg_cnt_q <= len_w - 16'd2;
                                state_q   <= ST_BODY;
                            end
                        end
                    end
                    ST_BODY: begin
                        if (sof_q) begin
                            case (body_idx_q)
                                3'd1: height_q[DIM_W-1:8] <= din[DIM_W-9:0];
                                3'd2: height_q[7:0]       <= din;
                                3'd3: width_q[DIM_W-1:8]  <= din[DIM_W-9:0];
                                3'd4: width_q[7:0]        <= din;
                                default: ;
                            endcase
                        end
                        if (body_idx_q != 3'd7) begin
                            body_idx_q <= body_idx_q + 3'd1;
                        end
                        seg_cnt_q <= seg_cnt_q - 16'd1;
                        if (seg_cnt_q == 16'd1) begin
                            if (sos_q) begin
                                state_q      <= ST_SCAN;
                                scan_start_q <= 1'b1;
                                in_scan_q    <= 1'b1;
                                pending_ff_q <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_SCAN: begin
                        if (!pending_ff_q) begin
                            if (din == MK_FF) begin
                                pending_ff_q <= 1'b1;
                            end
                        end else if (din == 8'h00 || is_rst_marker(din)) begin
                            pending_ff_q <= 1'b0;
                        end else if (din == MK_EOI) begin
                            pending_ff_q <= 1'b0;
                            scan_done_q  <= 1'b1;
                            in_scan_q    <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else if (din != MK_FF) begin
                            pending_ff_q <= 1'b0;
                            in_scan_q    <= 1'b0;
                            err_q        <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
            // Marker code after FF, from MARK or as an error exit out of SCAN;
            // placed last so an SOI clears an error raised in the same cycle.
            if (mark_now) begin
                state_q  <= md_w.nxt;
                sof_q    <= md_w.sof;
                sos_q    <= md_w.sos;
                len_lo_q <= 1'b0;
                if (md_w.soi) begin
                    frame_start_q <= 1'b1;
                    err_q         <= 1'b0;
                end
            end
        end
    end

    assign frame_start = frame_start_q;
    assign scan_start  = scan_start_q;
    assign scan_done   = scan_done_q;
    assign in_scan     = in_scan_q;
    assign width       = width_q;
    assign height      = height_q;
    assign err         = err_q;

`ifdef MJPG_READER_STATS_EN
    logic [31:0] stat_bytes_q;
    logic [31:0] stat_unstuff_q;
    logic [31:0] stat_frames_q;

    // Saturating traffic counters, cleared by reset only.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bytes_q   <= '0;
            stat_unstuff_q <= '0;
            stat_frames_q  <= '0;
        end else begin
            if (acc && stat_bytes_q != '1) begin
                stat_bytes_q <= stat_bytes_q + 32'd1;
            end
            if (acc && win_en && pending_ff_q && din == 8'h00 && stat_unstuff_q != '1) begin
                stat_unstuff_q <= stat_unstuff_q + 32'd1;
            end
            if (acc && win_en && pending_ff_q && din == MK_EOI && stat_frames_q != '1) begin
                stat_frames_q <= stat_frames_q + 32'd1;
            end
        end
    end

    assign stat_bytes   = stat_bytes_q;
    assign stat_unstuff = stat_unstuff_q;
    assign stat_frames  = stat_frames_q;
`endif

endmodule

// File: tb/tb_mjpg_stream_reader.sv
// tb_mjpg_stream_reader: directed checks of the MJPEG stream reader.
module tb_mjpg_stream_reader;
    import mjpg_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       take = '0;
    logic [ACC_W-1:0] win;
    logic [5:0]       win_len;
    logic             frame_start, scan_start, scan_done, in_scan, err;
    logic [DIM_W-1:0] width, height;
`ifdef MJPG_READER_STATS_EN
    logic [31:0]      stat_bytes, stat_unstuff, stat_frames;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] hdr [0:18] = '{8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h01, 8'hE0,
                               8'h02, 8'h80, 8'h03, 8'h01, 8'h22, 8'h00, 8'h02,
                               8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
    logic [7:0] sos [0:13] = '{8'hFF, 8'hDA, 8'h00, 8'h0C, 8'h03, 8'h01, 8'h00,
                               8'h02, 8'h11, 8'h03, 8'h11, 8'h00, 8'h3F, 8'h00};

    mjpg_stream_reader_if bus ();

    mjpg_stream_reader dut (
        .clk         (clk),
        .rst         (rst),
        .in_bus      (bus),
        .win         (win),
        .win_len     (win_len),
        .take        (take),
        .frame_start (frame_start),
        .scan_start  (scan_start),
        .scan_done   (scan_done),
        .in_scan     (in_scan),
        .width       (width),
        .height      (height),
        .err         (err)
`ifdef MJPG_READER_STATS_EN
        ,
        .stat_bytes  (stat_bytes),
        .stat_unstuff(stat_unstuff),
        .stat_frames (stat_frames)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one byte from a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [7:0] b, input logic [5:0] tk);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        take         = tk;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 40) else begin
            errors++;
            $error("FAIL send_timeout: byte 0x%0h observed in_ready low expected accept", b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        take         = '0;
    endtask

    task automatic idle(input logic [5:0] tk);
        take = tk;
        @(negedge clk);
        take = '0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_win", win, 32'h0);
        chk("rst_win_len", 32'(win_len), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pulses", {29'd0, frame_start, scan_start, scan_done}, 32'd0);
        chk("rst_in_scan", 32'(in_scan), 32'd0);
        chk("rst_width", 32'(width), 32'd0);
        chk("rst_height", 32'(height), 32'd0);

        // SOI and SOF0 header
        send(8'hFF, 0);
        send(8'hD8, 0);
        chk("soi_pulse", 32'(frame_start), 32'd1);
        idle(0);
        chk("soi_pulse_end", 32'(frame_start), 32'd0);
        foreach (hdr[i]) send(hdr[i], 0);
        chk("sof_height", 32'(height), 32'd480);
        chk("sof_width", 32'(width), 32'd640);
        chk("sof_in_scan", 32'(in_scan), 32'd0);

        // SOS header then scan data with stuffing
        foreach (sos[i]) send(sos[i], 0);
        chk("scan_start_pulse", 32'(scan_start), 32'd1);
        chk("scan_in_scan", 32'(in_scan), 32'd1);
        send(8'h12, 0);
        chk("scan_start_end", 32'(scan_start), 32'd0);
        chk("first_byte_win", win, 32'h1200_0000);
        send(8'hFF, 0);
        chk("ff_not_appended", 32'(win_len), 32'd8);
        send(8'h00, 0);
        chk("stuff_len", 32'(win_len), 32'd16);
        send(8'h34, 0);
        chk("unstuff_win", win, 32'h12FF_3400);
        chk("unstuff_len", 32'(win_len), 32'd24);

        // take and append together
        send(8'hAB, 5);
        chk("tk_app_len", 32'(win_len), 32'd27);
        chk("tk_app_byte_pos", 32'(win[12:5]), 32'hAB);
        chk("tk_app_win", win, 32'h5FE6_9560);

        // backpressure and FF/00 near the top of the window
        idle(3);
        chk("take3_win", win, 32'hFF34_AB00);
        send(8'h55, 0);
        chk("full_len", 32'(win_len), 32'd32);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        idle(12);
        chk("len20_in_ready", 32'(bus.in_ready), 32'd1);
        send(8'hFF, 0);
        chk("ff20_pending_ready", 32'(bus.in_ready), 32'd1);
        send(8'h00, 0);
        chk("ff00_len", 32'(win_len), 32'd28);
        chk("ff00_win", win, 32'h4AB5_5FF0);
        chk("len28_in_ready", 32'(bus.in_ready), 32'd0);

        // EOI with padding bits left unread
        idle(21);
        chk("pad_len", 32'(win_len), 32'd7);
        chk("pad_win", win, 32'hFE00_0000);
        send(8'hFF, 0);
        send(8'hFF, 0);
        send(8'hD9, 0);
        chk("eoi_pulse", 32'(scan_done), 32'd1);
        chk("eoi_len", 32'(win_len), 32'd0);
        chk("eoi_win", win, 32'h0);
        chk("eoi_in_scan", 32'(in_scan), 32'd0);
        chk("eoi_err", 32'(err), 32'd0);
        idle(3);
        chk("take_outside_len", 32'(win_len), 32'd0);
        chk("take_outside_err", 32'(err), 32'd0);
        chk("eoi_pulse_end", 32'(scan_done), 32'd0);

        // zero-length SOS body, then over-take
        send(8'hFF, 0);
        send(8'hDA, 0);
        send(8'h00, 0);
        send(8'h02, 0);
        chk("zlen_scan_start", 32'(scan_start), 32'd1);
        chk("zlen_in_scan", 32'(in_scan), 32'd1);
        send(8'h5A, 0);
        idle(4);
        chk("len4_win", win, 32'hA000_0000);
        chk("len4_len", 32'(win_len), 32'd4);
        idle(9);
        chk("overtake_err", 32'(err), 32'd1);
        chk("overtake_len", 32'(win_len), 32'd0);

        // unexpected marker inside the scan
        send(8'hFF, 0);
        send(8'hC4, 0);
        chk("dht_in_scan", 32'(in_scan), 32'd0);
        chk("dht_err", 32'(err), 32'd1);
        chk("dht_in_ready", 32'(bus.in_ready), 32'd1);

        // reset in the middle of the length field
        send(8'h00, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midlen_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("midlen_rst_len", 32'(win_len), 32'd0);
        chk("midlen_rst_err", 32'(err), 32'd0);
        send(8'hFF, 0);
        send(8'hD8, 0);
        chk("midlen_rst_idle", 32'(frame_start), 32'd1);

        // short length sets err; a later SOI clears it
        send(8'hFF, 0);
        send(8'hDA, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        chk("short_len_err", 32'(err), 32'd1);
        chk("short_len_in_scan", 32'(in_scan), 32'd0);
        send(8'hFF, 0);
        send(8'hD8, 0);
        chk("soi_clears_err", 32'(err), 32'd0);
        chk("soi_pulse2", 32'(frame_start), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
